// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the Simple CPU v1 datapath.
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, LATCH} fetch_state_t;
  localparam int CPU_DW = 8;
  localparam int CPU_AW = 8;
  localparam logic [7:0] CPU_RESET_PC = 8'h00;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with direct load, increment and pending-jump capture.
module pc_reg #(
  parameter int AW = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          idle,
  input  logic          jump_en,
  input  logic [AW-1:0] jump_addr,
  input  logic          apply,
  input  logic          inc,
  output logic [AW-1:0] pc
);
  logic [AW-1:0] pc_d, pc_q, jump_tgt_d, jump_tgt_q;
  logic jump_pend_d, jump_pend_q;
  // a jump arriving on the retire cycle itself is the newest and wins
  always_comb begin
    pc_d = idle && jump_en ? jump_addr :
           !apply          ? pc_q :
           jump_en         ? jump_addr :
           jump_pend_q     ? jump_tgt_q :
           inc             ? pc_q + 1'b1 : pc_q;
    jump_pend_d = apply ? 1'b0 : (!idle && jump_en) ? 1'b1 : jump_pend_q;
    jump_tgt_d  = (!idle && jump_en) ? jump_addr : jump_tgt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      jump_tgt_q  <= '0;
      jump_pend_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      jump_tgt_q  <= jump_tgt_d;
      jump_pend_q <= jump_pend_d;
    end
  end
  assign pc = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: pc/ir holder sequencing instruction fetch over a req/ack memory handshake.
module fetch_unit import cpu_pkg::*; #(
  parameter int DW = CPU_DW,
  parameter int AW = CPU_AW,
  parameter logic [AW-1:0] RESET_PC = CPU_RESET_PC,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          jump_en,
  input  logic [AW-1:0] jump_addr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          mem_req,
  output logic          sel_pc,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] ir,
  output logic          ir_valid,
  output logic          busy,
  output logic          fetch_err
);
  localparam logic [3:0] TLAST = 4'(TIMEOUT - 1);
  fetch_state_t state_d, state_q;
  logic [DW-1:0] ir_d, ir_q;
  logic [3:0] tcnt_d, tcnt_q;
  logic mem_req_d, mem_req_q, sel_pc_d, sel_pc_q, ir_valid_d, ir_valid_q;
  logic busy_d, busy_q, fetch_err_d, fetch_err_q;
  logic timeout;
  assign timeout = state_q == REQ && !mem_ack && tcnt_q == TLAST;
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    tcnt_d      = tcnt_q;
    mem_req_d   = mem_req_q;
    sel_pc_d    = sel_pc_q;
    ir_valid_d  = 1'b0;
    fetch_err_d = 1'b0;
    case (state_q)
      IDLE: if (start && !jump_en) begin
        state_d   = REQ;
        mem_req_d = 1'b1;
        sel_pc_d  = 1'b1;
        tcnt_d    = '0;
      end
      REQ: if (mem_ack) begin
        state_d    = LATCH;
        ir_d       = mem_rdata;
        mem_req_d  = 1'b0;
        ir_valid_d = 1'b1;
      end else if (timeout) begin
        state_d     = IDLE;
        mem_req_d   = 1'b0;
        sel_pc_d    = 1'b0;
        fetch_err_d = 1'b1;
      end else tcnt_d = tcnt_q + 4'd1;
      default: begin
        state_d  = IDLE;
        sel_pc_d = 1'b0;
      end
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ir_q        <= '0;
      tcnt_q      <= '0;
      mem_req_q   <= 1'b0;
      sel_pc_q    <= 1'b0;
      ir_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      tcnt_q      <= tcnt_d;
      mem_req_q   <= mem_req_d;
      sel_pc_q    <= sel_pc_d;
      ir_valid_q  <= ir_valid_d;
      busy_q      <= busy_d;
      fetch_err_q <= fetch_err_d;
    end
  end
  pc_reg #(.AW(AW), .RESET_PC(RESET_PC)) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .idle      (state_q == IDLE),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .apply     (state_q == LATCH || timeout),
    .inc       (state_q == LATCH),
    .pc        (pc)
  );
  assign mem_req   = mem_req_q;
  assign sel_pc    = sel_pc_q;
  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign busy      = busy_q;
  assign fetch_err = fetch_err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch sequencing, jumps, timeout and reset.
module tb_fetch_unit;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, jump_en = 1'b0, mem_ack = 1'b0;
  logic [7:0] jump_addr = '0, mem_rdata = '0;
  logic mem_req, sel_pc, ir_valid, busy, fetch_err;
  logic [7:0] pc, ir;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .jump_en(jump_en), .jump_addr(jump_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req), .sel_pc(sel_pc),
    .pc(pc), .ir(ir), .ir_valid(ir_valid), .busy(busy), .fetch_err(fetch_err)
  );
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic jump(input logic [7:0] a);
    jump_en = 1'b1;
    jump_addr = a;
    step();
    jump_en = 1'b0;
    check("jump_pc", pc, a);
  endtask
  task automatic fetch(input logic [7:0] d, input int gap);
    start = 1'b1;
    step();
    start = 1'b0;
    check("req_hi", 8'(mem_req), 8'd1);
    for (int i = 0; i < gap; i++) begin
      check("sel_pc_req", 8'(sel_pc), 8'd1);
      step();
    end
    mem_ack = 1'b1;
    mem_rdata = d;
    step();
    mem_ack = 1'b0;
    check("ir_valid_hi", 8'(ir_valid), 8'd1);
    check("ir_load", ir, d);
    check("req_lo", 8'(mem_req), 8'd0);
    step();
    check("ir_valid_lo", 8'(ir_valid), 8'd0);
    check("busy_lo", 8'(busy), 8'd0);
    check("sel_pc_lo", 8'(sel_pc), 8'd0);
  endtask
  initial begin
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rst_pc", pc, 8'h00);
    check("rst_ir", ir, 8'h00);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_req", 8'(mem_req), 8'd0);
    // basic fetch
    jump(8'h05);
    fetch(8'hA7, 3);
    check("basic_pc", pc, 8'h06);
    // ack outside REQ is ignored
    mem_ack = 1'b1;
    mem_rdata = 8'hAA;
    step();
    mem_ack = 1'b0;
    check("stray_ack_ir", ir, 8'hA7);
    check("stray_ack_busy", 8'(busy), 8'd0);
    // pc wrap
    jump(8'hFF);
    fetch(8'h3C, 1);
    check("wrap_pc", pc, 8'h00);
    // jumps while busy: last wins, applied at LATCH
    jump(8'h10);
    start = 1'b1;
    step();
    start = 1'b0;
    jump_en = 1'b1;
    jump_addr = 8'h40;
    step();
    jump_addr = 8'h44;
    step();
    jump_en = 1'b0;
    check("pend_pc_hold", pc, 8'h10);
    mem_ack = 1'b1;
    mem_rdata = 8'h55;
    step();
    mem_ack = 1'b0;
    step();
    check("pend_pc", pc, 8'h44);
    // timeout
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 14; i++) step();
    check("to_req_still", 8'(mem_req), 8'd1);
    check("to_err_early", 8'(fetch_err), 8'd0);
    step();
    check("to_err", 8'(fetch_err), 8'd1);
    check("to_req_lo", 8'(mem_req), 8'd0);
    check("to_busy", 8'(busy), 8'd0);
    check("to_pc", pc, 8'h44);
    check("to_ir", ir, 8'h55);
    step();
    check("to_err_pulse", 8'(fetch_err), 8'd0);
    fetch(8'h66, 0);
    check("refetch_pc", pc, 8'h45);
    // start + jump in IDLE: jump wins
    start = 1'b1;
    jump_en = 1'b1;
    jump_addr = 8'h20;
    step();
    start = 1'b0;
    jump_en = 1'b0;
    check("race_pc", pc, 8'h20);
    check("race_req", 8'(mem_req), 8'd0);
    check("race_busy", 8'(busy), 8'd0);
    // ack on the timeout cycle: ack wins
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 14; i++) step();
    mem_ack = 1'b1;
    mem_rdata = 8'h9E;
    step();
    mem_ack = 1'b0;
    check("race_ack_valid", 8'(ir_valid), 8'd1);
    check("race_ack_err", 8'(fetch_err), 8'd0);
    check("race_ack_ir", ir, 8'h9E);
    step();
    check("race_ack_pc", pc, 8'h21);
    // async reset mid-REQ
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("mid_req", 8'(mem_req), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", 8'(mem_req), 8'd0);
    check("arst_pc", pc, 8'h00);
    check("arst_ir", ir, 8'h00);
    check("arst_busy", 8'(busy), 8'd0);
    check("arst_valid", 8'(ir_valid), 8'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_busy", 8'(busy), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
